// File: rtl/sub_float64_sigs.sv
// sub_float64_sigs: binary64 magnitude subtraction with RNE rounding, ap handshake.
// Define SUB_LOCK_EN to XOR the loaded result with (working_key ^ LOCK_KEY).
module sub_float64_sigs #(
    parameter logic [63:0] LOCK_KEY = 64'h0
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        zSign,
    output logic [63:0] ap_return,
    input  logic [63:0] working_key
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ALIGN = 5'b00010,
        S_NORM  = 5'b00100,
        S_ROUND = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    localparam logic [63:0] DEFAULT_NAN = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] IMPLICIT    = 64'h4000_0000_0000_0000;
    localparam logic [63:0] QUIET_BIT   = 64'h0008_0000_0000_0000;

    state_t state_q, state_d;

    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        z_sign_q, z_sign_d;
    logic        sgn_q, sgn_d;
    logic [63:0] sig_q, sig_d;
    logic [15:0] exp_q, exp_d;
    logic        spec_q, spec_d;
    logic [63:0] spec_val_q, spec_val_d;
    logic [63:0] ret_q, ret_d;

    logic [10:0] a_exp, b_exp;
    logic [63:0] a_sig, b_sig;

    logic        al_spec;
    logic [63:0] al_val;
    logic [63:0] al_sig;
    logic [15:0] al_exp;
    logic        al_sign;
    logic [15:0] al_sh;
    logic [63:0] al_small;

    logic [6:0]  nm_lz;

    logic [63:0] rn_sig;
    logic [15:0] rn_exp;
    logic        rn_ovf;
    logic [53:0] rn_man;
    logic [63:0] rn_res;
    logic [63:0] result;
    logic [63:0] lock_mask;

    function automatic logic [63:0] jam(input logic [63:0] x,
                                        input logic [15:0] n);
        logic [63:0] mask;
        logic [63:0] r;
        mask = ~(64'hFFFF_FFFF_FFFF_FFFF << n[5:0]);
        if (n >= 16'd64) begin
            r = {63'd0, |x};
        end else begin
            r = (x >> n[5:0]) | {63'd0, |(x & mask)};
        end
        return r;
    endfunction

    function automatic logic [6:0] clz64(input logic [63:0] x);
        logic [6:0] n;
        logic       hit;
        n   = 7'd0;
        hit = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!hit && !x[i]) begin
                n = n + 7'd1;
            end else begin
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [63:0] nan_prop(input logic [63:0] x,
                                             input logic [63:0] y);
        logic y_nan;
        y_nan = (y[62:52] == 11'h7FF) && (y[51:0] != 52'd0);
        return y_nan ? (y | QUIET_BIT) : (x | QUIET_BIT);
    endfunction

    assign a_exp = a_q[62:52];
    assign b_exp = b_q[62:52];
    assign a_sig = {2'b00, a_q[51:0], 10'd0};
    assign b_sig = {2'b00, b_q[51:0], 10'd0};

    // Align: special operands resolve here, otherwise the smaller-exponent
    // significand is jammed right and subtracted from the larger one.
    always_comb begin
        al_spec  = 1'b0;
        al_val   = 64'd0;
        al_sig   = 64'd0;
        al_exp   = 16'd0;
        al_sign  = z_sign_q;
        al_sh    = 16'd0;
        al_small = 64'd0;
        if (a_exp == b_exp) begin
            if (a_exp == 11'h7FF) begin
                al_spec = 1'b1;
                al_val  = ((a_sig | b_sig) != 64'd0) ? nan_prop(a_q, b_q)
                                                    : DEFAULT_NAN;
            end else if (a_sig > b_sig) begin
                al_sig = a_sig - b_sig;
                al_exp = {5'd0, (a_exp == 11'd0) ? 11'd1 : a_exp};
            end else if (a_sig < b_sig) begin
                al_sig  = b_sig - a_sig;
                al_exp  = {5'd0, (a_exp == 11'd0) ? 11'd1 : a_exp};
                al_sign = ~z_sign_q;
            end else begin
                al_spec = 1'b1;
                al_val  = 64'd0;
            end
        end else if (a_exp < b_exp) begin
            if (b_exp == 11'h7FF) begin
                al_spec = 1'b1;
                al_val  = (b_sig != 64'd0) ? nan_prop(a_q, b_q)
                                           : {~z_sign_q, 11'h7FF, 52'd0};
            end else begin
                al_sh    = {5'd0, b_exp} - {5'd0, a_exp}
                         - ((a_exp == 11'd0) ? 16'd1 : 16'd0);
                al_small = jam((a_exp == 11'd0) ? a_sig : (a_sig | IMPLICIT),
                               al_sh);
                al_sig   = (b_sig | IMPLICIT) - al_small;
                al_exp   = {5'd0, b_exp};
                al_sign  = ~z_sign_q;
            end
        end else begin
            if (a_exp == 11'h7FF) begin
                al_spec = 1'b1;
                al_val  = (a_sig != 64'd0) ? nan_prop(a_q, b_q) : a_q;
            end else begin
                al_sh    = {5'd0, a_exp} - {5'd0, b_exp}
                         - ((b_exp == 11'd0) ? 16'd1 : 16'd0);
                al_small = jam((b_exp == 11'd0) ? b_sig : (b_sig | IMPLICIT),
                               al_sh);
                al_sig   = (a_sig | IMPLICIT) - al_small;
                al_exp   = {5'd0, a_exp};
            end
        end
    end

    assign nm_lz = clz64(sig_q);

    // Round to nearest even; exp_q is a signed 16-bit biased exponent.
    always_comb begin
        rn_sig = sig_q;
        rn_exp = exp_q;
        rn_ovf = 1'b0;
        if (exp_q >= 16'h07FD) begin
            if (($signed(exp_q) > $signed(16'h07FD))
                || ((exp_q == 16'h07FD)
                    && 1'((sig_q + 64'h200) >> 63))) begin
                rn_ovf = 1'b1;
            end else if (exp_q[15]) begin
                rn_sig = jam(sig_q, -exp_q);
                rn_exp = 16'd0;
            end
        end
        rn_man = 54'((rn_sig + 64'h200) >> 10);
        if (rn_sig[9:0] == 10'h200) begin
            rn_man[0] = 1'b0;
        end
        if (rn_man == 54'd0) begin
            rn_exp = 16'd0;
        end
        rn_res = {sgn_q, 63'd0} + {1'b0, rn_exp[10:0], 52'd0}
               + {10'd0, rn_man};
        if (rn_ovf) begin
            rn_res = {sgn_q, 11'h7FF, 52'd0};
        end
        result = spec_q ? spec_val_q : rn_res;
    end

`ifdef SUB_LOCK_EN
    assign lock_mask = working_key ^ LOCK_KEY;
`else
    logic unused_lock;
    assign unused_lock = ^{working_key, LOCK_KEY};
    assign lock_mask   = 64'd0;
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        z_sign_d   = z_sign_q;
        sgn_d      = sgn_q;
        sig_d      = sig_q;
        exp_d      = exp_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        ret_d      = ret_q;
        unique case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    a_d      = a;
                    b_d      = b;
                    z_sign_d = zSign;
                    state_d  = S_ALIGN;
                end
            end
            S_ALIGN: begin
                spec_d     = al_spec;
                spec_val_d = al_val;
                sig_d      = al_sig;
                exp_d      = al_exp;
                sgn_d      = al_sign;
                state_d    = S_NORM;
            end
            S_NORM: begin
                sig_d   = sig_q << (nm_lz - 7'd1);
                exp_d   = exp_q - {9'd0, nm_lz};
                state_d = S_ROUND;
            end
            S_ROUND: begin
                ret_d   = result ^ lock_mask;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= S_IDLE;
            a_q        <= 64'd0;
            b_q        <= 64'd0;
            z_sign_q   <= 1'b0;
            sgn_q      <= 1'b0;
            sig_q      <= 64'd0;
            exp_q      <= 16'd0;
            spec_q     <= 1'b0;
            spec_val_q <= 64'd0;
            ret_q      <= 64'd0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            z_sign_q   <= z_sign_d;
            sgn_q      <= sgn_d;
            sig_q      <= sig_d;
            exp_q      <= exp_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            ret_q      <= ret_d;
        end
    end

    assign ap_done   = (state_q == S_DONE);
    assign ap_ready  = ap_done;
    assign ap_idle   = (state_q == S_IDLE) && !ap_start;
    assign ap_return = ret_q;

endmodule

// File: tb/tb_sub_float64_sigs.sv
// tb_sub_float64_sigs: scoreboard bench for sub_float64_sigs.
// Expected results and done times are queued at issue and checked on ap_done.
module tb_sub_float64_sigs;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        zSign;
    logic [63:0] ap_return;
    logic [63:0] working_key;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    time         t_q[$];
    logic [63:0] mon_e;
    time         mon_t;

    sub_float64_sigs dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .a           (a),
        .b           (b),
        .zSign       (zSign),
        .ap_return   (ap_return),
        .working_key (working_key)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [63:0] lockx(input logic [63:0] e);
`ifdef SUB_LOCK_EN
        return e ^ 64'h1;
`else
        return e;
`endif
    endfunction

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge ap_clk) begin
        if (ap_done) begin
            checks++;
            if (ap_ready !== 1'b1) begin
                failures++;
                $display("FAIL ready: got %b want 1", ap_ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got done ret=%h at %0t want none",
                         ap_return, $time);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = t_q.pop_front();
                if (ap_return !== mon_e) begin
                    failures++;
                    $display("FAIL result: got %h want %h", ap_return, mon_e);
                end
                checks++;
                if ($time != mon_t) begin
                    failures++;
                    $display("FAIL latency: done at %0t want %0t", $time, mon_t);
                end
            end
        end
    end

    task automatic issue(input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic tz, input logic [63:0] te);
        @(negedge ap_clk);
        a        = ta;
        b        = tb_v;
        zSign    = tz;
        ap_start = 1'b1;
        exp_q.push_back(lockx(te));
        t_q.push_back($time + 40);
        @(negedge ap_clk);
        ap_start = 1'b0;
        a        = ~ta;
        b        = ~tb_v;
        zSign    = ~tz;
        repeat (4) @(negedge ap_clk);
    endtask

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    typedef struct {
        logic [63:0] va;
        logic [63:0] vb;
        logic        vz;
        logic [63:0] ve;
    } vec_t;

    vec_t vecs[$];

    initial begin
        ap_rst      = 1'b1;
        ap_start    = 1'b0;
        a           = 64'd0;
        b           = 64'd0;
        zSign       = 1'b0;
        working_key = 64'h1;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("rst_return", ap_return, 64'd0);
        check("rst_done", {63'd0, ap_done}, 64'd0);
        check("rst_ready", {63'd0, ap_ready}, 64'd0);
        check("rst_idle", {63'd0, ap_idle}, 64'd1);

        vecs.push_back('{64'h3FF0000000000000, 64'h3FE0000000000000, 1'b0, 64'h3FE0000000000000});
        vecs.push_back('{64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 64'h0000000000000000});
        vecs.push_back('{64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'hBFF0000000000000});
        vecs.push_back('{64'h7FF0000000000000, 64'h7FF0000000000000, 1'b0, 64'h7FFFFFFFFFFFFFFF});
        vecs.push_back('{64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000001});
        vecs.push_back('{64'h0000000000000003, 64'h0000000000000001, 1'b0, 64'h0000000000000002});
        vecs.push_back('{64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 64'hBFF0000000000000});
        vecs.push_back('{64'h3FF0000000000000, 64'h7FF0000000000000, 1'b0, 64'hFFF0000000000000});
        vecs.push_back('{64'h7FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h7FF0000000000000});
        vecs.push_back('{64'h3FF0000000000000, 64'h7FF0000000000001, 1'b0, 64'h7FF8000000000001});
        vecs.push_back('{64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FEFFFFFFFFFFFFF});
        vecs.push_back('{64'h3FF0000000000000, 64'h3C90000000000000, 1'b0, 64'h3FF0000000000000});
        vecs.push_back('{64'h0010000000000000, 64'h0000000000000001, 1'b0, 64'h000FFFFFFFFFFFFF});

        foreach (vecs[i]) begin
            issue(vecs[i].va, vecs[i].vb, vecs[i].vz, vecs[i].ve);
        end

        // Back-to-back: start held high, second op accepted right after DONE.
        @(negedge ap_clk);
        a        = 64'h4000000000000000;
        b        = 64'h3FF0000000000000;
        zSign    = 1'b1;
        ap_start = 1'b1;
        exp_q.push_back(lockx(64'hBFF0000000000000));
        t_q.push_back($time + 40);
        @(negedge ap_clk);
        a     = 64'h3FF0000000000000;
        b     = 64'h3FE0000000000000;
        zSign = 1'b0;
        repeat (4) @(negedge ap_clk);
        exp_q.push_back(lockx(64'h3FE0000000000000));
        t_q.push_back($time + 40);
        @(negedge ap_clk);
        ap_start = 1'b0;
        a        = 64'h0;
        b        = 64'h0;
        repeat (4) @(negedge ap_clk);

        // Reset during NORM aborts the op: no done, ap_return cleared.
        @(negedge ap_clk);
        a        = 64'h3FF0000000000000;
        b        = 64'h4000000000000000;
        zSign    = 1'b0;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        check("abort_return", ap_return, 64'd0);
        check("abort_done", {63'd0, ap_done}, 64'd0);
        check("abort_idle", {63'd0, ap_idle}, 64'd1);
        repeat (8) @(negedge ap_clk);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
